// File: rtl/mem_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_sram_ctrl_if
// Purpose  : Bundles the pipeline-side request/response signals and the
//            external 16-bit asynchronous SRAM pad signals of the data-memory
//            access stage.
// Ports    : pipeline side - MEM_R_EN, MEM_W_EN, ALU_result, ST_val,
//                            MEM_result, ready
//            SRAM side     - SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_in,
//                            SRAM_DQ_oe, SRAM_WE_N
//            slave modport : the controller; master modport : its environment
// Revision : 1.0 - initial release
// ============================================================================
interface mem_sram_ctrl_if #(
    parameter int SRAM_AW = 18
);
    logic               MEM_R_EN;
    logic               MEM_W_EN;
    logic [31:0]        ALU_result;
    logic [31:0]        ST_val;
    logic [31:0]        MEM_result;
    logic               ready;
    logic [SRAM_AW-1:0] SRAM_ADDR;
    logic [15:0]        SRAM_DQ_out;
    logic [15:0]        SRAM_DQ_in;
    logic               SRAM_DQ_oe;
    logic               SRAM_WE_N;

    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_result, ST_val, SRAM_DQ_in,
        output MEM_result, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
    );

    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_result, ST_val, SRAM_DQ_in,
        input  MEM_result, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
    );
endinterface
`default_nettype wire

// File: rtl/mem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_sram_ctrl
// Purpose  : Data-memory access stage. Splits one 32-bit load/store into two
//            16-bit accesses (low halfword, then high halfword) on an external
//            asynchronous SRAM. ready is low while an access is in flight so
//            the pipeline can freeze.
// Ports    : clk - pipeline clock
//            rst - synchronous, active-low reset
//            bus - mem_sram_ctrl_if.slave (pipeline request/response + pads)
// Revision : 1.0 - initial release
// ============================================================================
module mem_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_sram_ctrl_if.slave bus
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WAIT_CYCLES);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LO   = 2'd1;
    localparam logic [1:0] c_HI   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SRAM_AW-2:0] r_word;
    logic [31:0]        r_st_val;
    logic               r_is_wr;
    logic [31:0]        r_mem_result;
    logic [SRAM_AW-1:0] r_sram_addr;

    logic               w_request;
    logic               w_last;
    logic               w_in_phase;
    logic [SRAM_AW-2:0] w_word;
    logic               w_ready;
    logic               w_we_n;
    logic               w_oe;
    logic [15:0]        w_dq_out;

    assign w_request  = bus.MEM_R_EN | bus.MEM_W_EN;
    assign w_last     = (r_cnt == c_LAST);
    assign w_in_phase = (r_state == c_LO) || (r_state == c_HI);
    // Word index relative to BASE_ADDR; the truncation makes out-of-range
    // addresses wrap around the SRAM and drops the byte offset bits.
    assign w_word     = (SRAM_AW-1)'((bus.ALU_result - BASE_ADDR) >> 2);

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_ready = ~w_request;
                if (w_request) w_next_state = c_LO;
            end
            c_LO:   if (w_last) w_next_state = c_HI;
            c_HI:   if (w_last) w_next_state = c_DONE;
            c_DONE: begin
                w_ready      = 1'b1;
                w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase

        // Write strobe is held low for every cycle of both store phases.
        w_oe     = w_in_phase & r_is_wr;
        w_we_n   = ~w_oe;
        w_dq_out = 16'h0000;
        if (w_oe) w_dq_out = (r_state == c_HI) ? r_st_val[31:16] : r_st_val[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_word       <= '0;
            r_st_val     <= 32'h0;
            r_is_wr      <= 1'b0;
            r_mem_result <= 32'h0;
            r_sram_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_IDLE: begin
                    if (w_request) begin
                        r_word      <= w_word;
                        r_st_val    <= bus.ST_val;
                        r_is_wr     <= bus.MEM_W_EN;  // store wins if both set
                        r_sram_addr <= {w_word, 1'b0};
                        r_cnt       <= '0;
                    end
                end
                c_LO: begin
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_sram_addr <= {r_word, 1'b1};
                        if (!r_is_wr) r_mem_result[15:0] <= bus.SRAM_DQ_in;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_HI: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (!r_is_wr) r_mem_result[31:16] <= bus.SRAM_DQ_in;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready       = w_ready;
    assign bus.MEM_result  = r_mem_result;
    assign bus.SRAM_ADDR   = r_sram_addr;
    assign bus.SRAM_DQ_out = w_dq_out;
    assign bus.SRAM_DQ_oe  = w_oe;
    assign bus.SRAM_WE_N   = w_we_n;

endmodule
`default_nettype wire

// File: tb/tb_mem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_sram_ctrl
// Purpose  : Self-checking bench for mem_sram_ctrl. Two instances: default
//            timing (WAIT_CYCLES=1) and WAIT_CYCLES=0. Each drives a small
//            behavioural SRAM that commits a halfword when the write strobe
//            ends or moves to another address, and discards it on reset.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sram_ctrl;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_res;
        logic [7:0]  lo_idx;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    logic clk;
    logic rst;
    logic mem_init;

    int n_checks;
    int n_errors;

    mem_sram_ctrl_if #(.SRAM_AW(18)) bus_a ();
    mem_sram_ctrl_if #(.SRAM_AW(18)) bus_b ();

    mem_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mem_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM models ----------------
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic        pend_a, pend_b;
    logic [7:0]  pa_addr, pb_addr;
    logic [15:0] pa_data, pb_data;

    assign bus_a.SRAM_DQ_in = mem_a[bus_a.SRAM_ADDR[7:0]];
    assign bus_b.SRAM_DQ_in = mem_b[bus_b.SRAM_ADDR[7:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 16'hA000 + 16'(i);
            pend_a <= 1'b0;
        end else if (!rst) begin
            pend_a <= 1'b0;
        end else if (!bus_a.SRAM_WE_N) begin
            if (pend_a && pa_addr != bus_a.SRAM_ADDR[7:0]) mem_a[pa_addr] <= pa_data;
            pend_a  <= 1'b1;
            pa_addr <= bus_a.SRAM_ADDR[7:0];
            pa_data <= bus_a.SRAM_DQ_out;
        end else if (pend_a) begin
            mem_a[pa_addr] <= pa_data;
            pend_a         <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 16'hB000 + 16'(i);
            pend_b <= 1'b0;
        end else if (!rst) begin
            pend_b <= 1'b0;
        end else if (!bus_b.SRAM_WE_N) begin
            if (pend_b && pb_addr != bus_b.SRAM_ADDR[7:0]) mem_b[pb_addr] <= pb_data;
            pend_b  <= 1'b1;
            pb_addr <= bus_b.SRAM_ADDR[7:0];
            pb_data <= bus_b.SRAM_DQ_out;
        end else if (pend_b) begin
            mem_b[pb_addr] <= pb_data;
            pend_b         <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the DONE edge.
    task automatic txn_a(input vec_t v, input int idx);
        int  lows;
        int  we_lows;
        bit  done;
        lows    = 0;
        we_lows = 0;
        done    = 1'b0;
        bus_a.MEM_R_EN   = v.rd;
        bus_a.MEM_W_EN   = v.wr;
        bus_a.ALU_result = v.addr;
        bus_a.ST_val     = v.wdata;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!bus_a.SRAM_WE_N) we_lows++;
            if (bus_a.ready) begin
                done = 1'b1;
                check($sformatf("v%0d result", idx), bus_a.MEM_result, v.exp_res);
            end else begin
                lows++;
            end
            @(posedge clk);
            #1;
        end
        bus_a.MEM_R_EN = 1'b0;
        bus_a.MEM_W_EN = 1'b0;
        check($sformatf("v%0d completed", idx), 32'(done), 32'd1);
        check($sformatf("v%0d ready-low cycles", idx), 32'(lows), 32'd5);
        check($sformatf("v%0d WE_N-low cycles", idx), 32'(we_lows), v.wr ? 32'd4 : 32'd0);
        check($sformatf("v%0d sram lo", idx), 32'(mem_a[v.lo_idx]), 32'(v.exp_lo));
        check($sformatf("v%0d sram hi", idx), 32'(mem_a[v.lo_idx + 8'd1]), 32'(v.exp_hi));
    endtask

    vec_t vecs [9];
    logic [7:0] exp_pat;
    logic [31:0] exp_b [2];

    initial begin
        n_checks = 0;
        n_errors = 0;

        //            rd    wr    addr        wdata         exp_res       lo     exp_lo    exp_hi
        vecs[0] = '{1'b0, 1'b1, 32'd1024,   32'h12345678, 32'h00000000, 8'h00, 16'h5678, 16'h1234};
        vecs[1] = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'h12345678, 8'h00, 16'h5678, 16'h1234};
        vecs[2] = '{1'b1, 1'b0, 32'd1028,   32'h0,        32'hA003A002, 8'h02, 16'hA002, 16'hA003};
        vecs[3] = '{1'b1, 1'b1, 32'd1032,   32'hCAFEBABE, 32'hA003A002, 8'h04, 16'hBABE, 16'hCAFE};
        vecs[4] = '{1'b1, 1'b0, 32'd1032,   32'h0,        32'hCAFEBABE, 8'h04, 16'hBABE, 16'hCAFE};
        vecs[5] = '{1'b1, 1'b0, 32'd1027,   32'h0,        32'h12345678, 8'h00, 16'h5678, 16'h1234};
        vecs[6] = '{1'b0, 1'b1, 32'd1020,   32'h55AA33CC, 32'h12345678, 8'hFE, 16'h33CC, 16'h55AA};
        vecs[7] = '{1'b1, 1'b0, 32'd1020,   32'h0,        32'h55AA33CC, 8'hFE, 16'h33CC, 16'h55AA};
        vecs[8] = '{1'b1, 1'b0, 32'd525312, 32'h0,        32'h12345678, 8'h00, 16'h5678, 16'h1234};

        rst      = 1'b0;
        mem_init = 1'b1;
        bus_a.MEM_R_EN = 1'b0; bus_a.MEM_W_EN = 1'b0; bus_a.ALU_result = 32'h0; bus_a.ST_val = 32'h0;
        bus_b.MEM_R_EN = 1'b0; bus_b.MEM_W_EN = 1'b0; bus_b.ALU_result = 32'h0; bus_b.ST_val = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        rst      = 1'b1;

        // Idle after reset
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle ready",      32'(bus_a.ready),       32'd1);
        check("idle WE_N",       32'(bus_a.SRAM_WE_N),   32'd1);
        check("idle oe",         32'(bus_a.SRAM_DQ_oe),  32'd0);
        check("idle MEM_result", bus_a.MEM_result,       32'h0);
        check("idle SRAM_ADDR",  32'(bus_a.SRAM_ADDR),   32'h0);
        check("idle DQ_out",     32'(bus_a.SRAM_DQ_out), 32'h0);
        check("idle B ready",    32'(bus_b.ready),       32'd1);
        check("idle B result",   bus_b.MEM_result,       32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) txn_a(vecs[i], i);

        // Reset during the second cycle of the high phase of a store
        bus_a.MEM_W_EN   = 1'b1;
        bus_a.ALU_result = 32'd1024;
        bus_a.ST_val     = 32'hDEADBEEF;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("abort HI WE_N", 32'(bus_a.SRAM_WE_N), 32'd0);
        check("abort HI addr", 32'(bus_a.SRAM_ADDR), 32'd1);
        rst            = 1'b0;
        bus_a.MEM_W_EN = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort ready",      32'(bus_a.ready),      32'd1);
        check("abort WE_N",       32'(bus_a.SRAM_WE_N),  32'd1);
        check("abort oe",         32'(bus_a.SRAM_DQ_oe), 32'd0);
        check("abort MEM_result", bus_a.MEM_result,      32'h0);
        check("abort SRAM_ADDR",  32'(bus_a.SRAM_ADDR),  32'h0);
        check("abort sram[0]",    32'(mem_a[0]),         32'h0000BEEF);
        check("abort sram[1]",    32'(mem_a[1]),         32'h00001234);
        @(posedge clk);
        #1;
        begin
            vec_t v;
            v = '{1'b1, 1'b0, 32'd1024, 32'h0, 32'h1234BEEF, 8'h00, 16'hBEEF, 16'h1234};
            txn_a(v, 9);
        end

        // WAIT_CYCLES=0: two back-to-back loads
        exp_pat  = 8'b1000_1000;   // bit c = ready in cycle c
        exp_b[0] = 32'hB003B002;
        exp_b[1] = 32'hB005B004;
        bus_b.MEM_R_EN   = 1'b1;
        bus_b.ALU_result = 32'd1028;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                check($sformatf("B ready cycle %0d", c), 32'(bus_b.ready), 32'(exp_pat[c]));
                if (bus_b.ready && k < 2) begin
                    check($sformatf("B load %0d result", k), bus_b.MEM_result, exp_b[k]);
                    k++;
                end
                @(posedge clk);
                #1;
                if (c == 3) bus_b.ALU_result = 32'd1032;
            end
            check("B loads seen", 32'(k), 32'd2);
        end
        bus_b.MEM_R_EN = 1'b0;

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
